// File: rtl/channel_scan_sequencer_pkg.sv
// Shared types and constants for the channel scan sequencer.
//   scan_state_t : scan FSM states
//   NUM_CH/SEL_W : demux channel count and select width
//   PTR_W        : scan pointer width; one bit wider than the select so the
//                  value NUM_CH can mark the end of a pass
package gyro_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int PTR_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    DWELL,
    STROBE,
    WAIT_ACK
  } scan_state_t;

  // Pointer to resume the search after a channel completes. Zero-extended so
  // channel 7 yields 8 (end of pass) instead of wrapping to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return {1'b0, sel} + PTR_W'(1);
  endfunction

endpackage

// File: rtl/channel_scan_sequencer_if.sv
// Command/status bundle between a scan controller and the sequencer.
//   master : drives start/stop/config and the downstream acknowledge,
//            observes strobe/select and status pulses
//   slave  : the sequencer side
interface channel_scan_if #(
  parameter int DWELL_W = 16
);
  import gyro_scan_pkg::*;

  logic               start;
  logic               stop;
  logic               continuous;
  logic [NUM_CH-1:0]  ch_mask;
  logic [DWELL_W-1:0] dwell_cycles;
  logic               chan_ack;

  logic               chan_strobe;
  logic [SEL_W-1:0]   chan_sel;
  logic               busy;
  logic               scan_done;
  logic               cfg_err;
  logic               ack_timeout;

  modport master (
    output start, stop, continuous, ch_mask, dwell_cycles, chan_ack,
    input  chan_strobe, chan_sel, busy, scan_done, cfg_err, ack_timeout
  );

  modport slave (
    input  start, stop, continuous, ch_mask, dwell_cycles, chan_ack,
    output chan_strobe, chan_sel, busy, scan_done, cfg_err, ack_timeout
  );

endinterface

// File: rtl/channel_scan_sequencer_ch_mask_finder.sv
// Combinational search for the lowest enabled channel at or above a pointer.
//   mask  : channel enable mask, bit n = channel n
//   ptr   : first channel index eligible (NUM_CH or above finds nothing)
//   found : an eligible enabled channel exists
//   idx   : index of that channel (0 when nothing is found)
module ch_mask_finder
  import gyro_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [PTR_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  // Walk from the top down so the lowest qualifying channel is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (PTR_W'(i) >= ptr)) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Round-robin scan sequencer feeding the 1-to-8 channel demux.
// Steps through the enabled channels of a latched mask; per channel it
// settles for max(dwell,1) cycles, emits a one-cycle strobe with a stable
// select, then waits for an acknowledge (or timeout) before moving on.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : channel_scan_if slave (start/stop/config/ack in; strobe, select,
//           busy and status pulses out, all registered)
module channel_scan_sequencer
  import gyro_scan_pkg::*;
#(
  parameter int               DWELL_W = 16,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] ACK_TMO = 16'd1000
) (
  input  logic clk,
  input  logic reset,
  channel_scan_if.slave bus
);

  // Counter value in the last WAIT_ACK cycle before a forced advance; the
  // counter is zero in the strobe cycle, so the timeout pulse lands exactly
  // ACK_TMO cycles after the strobe.
  localparam logic [TMO_W-1:0] TMO_LAST = ACK_TMO - TMO_W'(1);

  scan_state_t        state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [NUM_CH-1:0]  mask_q, mask_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               cont_q, cont_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic               strobe_q, strobe_n;
  logic               busy_q;
  logic               done_q, done_n;
  logic               cfg_err_q, cfg_err_n;
  logic               tmo_q, tmo_n;

  logic               hit;
  logic [SEL_W-1:0]   hit_idx;

  ch_mask_finder u_finder (
    .mask  (mask_q),
    .ptr   (ptr),
    .found (hit),
    .idx   (hit_idx)
  );

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    mask_n      = mask_q;
    dwell_n     = dwell_q;
    cont_n      = cont_q;
    dwell_cnt_n = dwell_cnt;
    tmo_cnt_n   = tmo_cnt;
    sel_n       = sel_q;
    strobe_n    = 1'b0;
    done_n      = 1'b0;
    cfg_err_n   = 1'b0;
    tmo_n       = 1'b0;

    // stop overrides everything outside IDLE, including a pending ack.
    if ((state != IDLE) && bus.stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (bus.ch_mask != '0) begin
              mask_n  = bus.ch_mask;
              dwell_n = bus.dwell_cycles;
              cont_n  = bus.continuous;
              ptr_n   = '0;
              state_n = SEEK;
            end else begin
              cfg_err_n = 1'b1;
            end
          end
        end

        SEEK: begin
          if (hit) begin
            sel_n       = hit_idx;
            dwell_cnt_n = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
            state_n     = DWELL;
          end else begin
            done_n = 1'b1;
            if (cont_q) begin
              ptr_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end

        DWELL: begin
          if (dwell_cnt <= DWELL_W'(1)) begin
            strobe_n  = 1'b1;
            tmo_cnt_n = '0;
            state_n   = STROBE;
          end else begin
            dwell_cnt_n = dwell_cnt - DWELL_W'(1);
          end
        end

        STROBE: begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
          state_n   = WAIT_ACK;
        end

        WAIT_ACK: begin
          if (bus.chan_ack || (tmo_cnt == TMO_LAST)) begin
            tmo_n   = !bus.chan_ack;
            ptr_n   = next_ptr(sel_q);
            state_n = SEEK;
          end else begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      mask_q    <= '0;
      dwell_q   <= '0;
      cont_q    <= 1'b0;
      dwell_cnt <= '0;
      tmo_cnt   <= '0;
      sel_q     <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      mask_q    <= mask_n;
      dwell_q   <= dwell_n;
      cont_q    <= cont_n;
      dwell_cnt <= dwell_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
      sel_q     <= sel_n;
      strobe_q  <= strobe_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
      cfg_err_q <= cfg_err_n;
      tmo_q     <= tmo_n;
    end
  end

  assign bus.chan_strobe = strobe_q;
  assign bus.chan_sel    = sel_q;
  assign bus.busy        = busy_q;
  assign bus.scan_done   = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.ack_timeout = tmo_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Self-checking bench for channel_scan_sequencer: table of scan scenarios
// plus hand-written stop/reset/config-error sequences. Expected channel
// selects are queued when a scan is started and popped on every strobe.
module tb_channel_scan_sequencer;

  localparam int ACK_TMO = 1000;
  localparam int GUARD   = 20000;

  typedef struct {
    logic [7:0]  mask;
    logic [15:0] dwell;
    logic        cont;
    int          ack_dly;     // cycles from strobe to ack; 0 = never ack
    int          passes;
    int          exp_lat;     // start cycle to first strobe
    int          exp_strobes;
    int          exp_tmo;
  } vec_t;

  logic clk;
  logic reset;

  channel_scan_if #(.DWELL_W(16)) bus ();

  channel_scan_sequencer #(
    .DWELL_W (16),
    .TMO_W   (16),
    .ACK_TMO (16'd1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_strobe = 0;
  int n_done   = 0;
  int n_cfg    = 0;
  int n_tmo    = 0;
  int ack_dly  = 0;
  int ack_cnt  = 0;
  int last_strobe_cyc  = 0;
  int first_strobe_cyc = -1;
  int exp_q[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock: outputs sampled on the falling edge, ack driven for the next edge.
  task automatic tick();
    int exp_sel;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.chan_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) bus.chan_ack = 1'b1;
    end
    if (bus.chan_strobe) begin
      n_strobe++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL strobe_sel: unexpected strobe on channel %0d, none expected", bus.chan_sel);
      end else begin
        exp_sel = exp_q.pop_front();
        check("strobe_sel", 32'(bus.chan_sel), exp_sel);
      end
      ack_cnt = ack_dly;
    end
    if (bus.scan_done) n_done++;
    if (bus.cfg_err) n_cfg++;
    if (bus.ack_timeout) begin
      n_tmo++;
      check("tmo_delay", cyc - last_strobe_cyc, ACK_TMO);
    end
  endtask

  task automatic run_scan(input vec_t v, input int id);
    int start_cyc, done0, strobe0, tmo0, guard;
    for (int p = 0; p < v.passes; p++)
      for (int i = 0; i < 8; i++)
        if (v.mask[i]) exp_q.push_back(i);
    ack_dly = v.ack_dly;
    ack_cnt = 0;
    done0 = n_done; strobe0 = n_strobe; tmo0 = n_tmo;
    first_strobe_cyc = -1;
    bus.ch_mask = v.mask;
    bus.dwell_cycles = v.dwell;
    bus.continuous = v.cont;
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    // Config inputs moving mid-scan must not matter.
    bus.ch_mask = ~v.mask;
    bus.dwell_cycles = v.dwell + 16'd7;
    bus.continuous = ~v.cont;
    guard = 0;
    if (v.cont) begin
      while ((n_done - done0 < v.passes) && guard < GUARD) begin tick(); guard++; end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
    end else begin
      while (bus.busy && guard < GUARD) begin tick(); guard++; end
    end
    check($sformatf("v%0d_in_time", id), 32'(guard < GUARD), 1);
    check($sformatf("v%0d_first_lat", id), first_strobe_cyc - start_cyc, v.exp_lat);
    check($sformatf("v%0d_strobes", id), n_strobe - strobe0, v.exp_strobes);
    check($sformatf("v%0d_scan_done", id), n_done - done0, v.passes);
    check($sformatf("v%0d_timeouts", id), n_tmo - tmo0, v.exp_tmo);
    check($sformatf("v%0d_busy_end", id), 32'(bus.busy), 0);
    check($sformatf("v%0d_queue_left", id), exp_q.size(), 0);
    exp_q.delete();
    ack_cnt = 0;
    bus.ch_mask = '0;
    bus.dwell_cycles = '0;
    bus.continuous = 1'b0;
    tick();
  endtask

  initial begin
    int s0, d0, c0, g;
    vec_t r;

    //            mask   dwell  cont ack pass lat strobes tmo
    vecs[0] = '{8'h05, 16'd3, 1'b0, 2, 1, 5, 2, 0};
    vecs[1] = '{8'h80, 16'd0, 1'b1, 1, 3, 3, 3, 0};
    vecs[2] = '{8'h03, 16'd2, 1'b0, 0, 1, 4, 2, 2};
    vecs[3] = '{8'hFF, 16'd1, 1'b0, 1, 1, 3, 8, 0};
    vecs[4] = '{8'h5A, 16'd5, 1'b1, 3, 2, 7, 8, 0};

    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
    bus.ch_mask = '0; bus.dwell_cycles = '0; bus.chan_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_busy", 32'(bus.busy), 0);
    check("rst_strobe", 32'(bus.chan_strobe), 0);
    check("rst_sel", 32'(bus.chan_sel), 0);
    check("rst_scan_done", 32'(bus.scan_done), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);
    check("rst_ack_timeout", 32'(bus.ack_timeout), 0);

    for (int i = 0; i < 5; i++) run_scan(vecs[i], i);

    // Empty mask: config error pulse only.
    s0 = n_strobe; c0 = n_cfg;
    bus.ch_mask = 8'h00; bus.dwell_cycles = 16'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("cfg_err_pulse", 32'(bus.cfg_err), 1);
    check("cfg_err_busy", 32'(bus.busy), 0);
    tick();
    check("cfg_err_clear", 32'(bus.cfg_err), 0);
    for (int i = 0; i < 10; i++) tick();
    check("cfg_err_count", n_cfg - c0, 1);
    check("cfg_err_no_strobe", n_strobe - s0, 0);

    // Stop during DWELL on channel 4.
    s0 = n_strobe; d0 = n_done;
    ack_dly = 1;
    bus.ch_mask = 8'hF0; bus.dwell_cycles = 16'd10; bus.continuous = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("stop_sel", 32'(bus.chan_sel), 4);
    check("stop_busy_before", 32'(bus.busy), 1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy_after", 32'(bus.busy), 0);
    check("stop_strobe", 32'(bus.chan_strobe), 0);
    for (int i = 0; i < 20; i++) tick();
    check("stop_no_strobe", n_strobe - s0, 0);
    check("stop_no_done", n_done - d0, 0);

    // stop and start together in IDLE: stays idle.
    bus.ch_mask = 8'h01; bus.dwell_cycles = 16'd1; bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("stopstart_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 10; i++) tick();
    check("stopstart_no_strobe", n_strobe - s0, 0);

    // Reset while waiting for an ack on channel 2.
    s0 = n_strobe;
    ack_dly = 0;
    exp_q.push_back(2);
    bus.ch_mask = 8'h0C; bus.dwell_cycles = 16'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    g = 0;
    while (n_strobe == s0 && g < 100) begin tick(); g++; end
    check("rst_wait_strobe_seen", n_strobe - s0, 1);
    tick(); tick(); tick();
    check("rst_wait_busy_before", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_strobe", 32'(bus.chan_strobe), 0);
    check("rst_mid_sel", 32'(bus.chan_sel), 0);
    check("rst_mid_done", 32'(bus.scan_done), 0);
    check("rst_mid_tmo", 32'(bus.ack_timeout), 0);
    tick();
    check("rst_mid_stays_idle", 32'(bus.busy), 0);
    r = '{8'h0D, 16'd2, 1'b0, 1, 1, 4, 3, 0};
    run_scan(r, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
